// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg: shared FSM state type, screen limits and seven-segment glyphs.
`default_nettype none

package score_keeper_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      PLAY  = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam int MAX_X = 640;
   localparam int MAX_Y = 480;

   // Glyph bit order is {a,b,c,d,e,f,g}, bit 6 = segment a.
   localparam logic [6:0] SEG_0 = 7'h7E;
   localparam logic [6:0] SEG_1 = 7'h30;
   localparam logic [6:0] SEG_2 = 7'h6D;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h33;
   localparam logic [6:0] SEG_5 = 7'h5B;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h7B;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h1F;
   localparam logic [6:0] SEG_C = 7'h4E;
   localparam logic [6:0] SEG_D = 7'h3D;
   localparam logic [6:0] SEG_E = 7'h4F;
   localparam logic [6:0] SEG_F = 7'h47;

   function automatic logic [6:0] seg_pattern(input logic [3:0] value);
      logic [6:0] pat;
      case (value)
         4'h0:    pat = SEG_0;
         4'h1:    pat = SEG_1;
         4'h2:    pat = SEG_2;
         4'h3:    pat = SEG_3;
         4'h4:    pat = SEG_4;
         4'h5:    pat = SEG_5;
         4'h6:    pat = SEG_6;
         4'h7:    pat = SEG_7;
         4'h8:    pat = SEG_8;
         4'h9:    pat = SEG_9;
         4'hA:    pat = SEG_A;
         4'hB:    pat = SEG_B;
         4'hC:    pat = SEG_C;
         4'hD:    pat = SEG_D;
         4'hE:    pat = SEG_E;
         default: pat = SEG_F;
      endcase
      return pat;
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] value);
      return (value == 4'hF) ? value : value + 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/score_keeper_seg_digit.sv
// seg_digit: tests whether pixel (x, y) falls on a lit segment of one hex digit box.
`default_nettype none

module seg_digit
   import score_keeper_pkg::*;
#(
   parameter int DIGIT_W = 20,
   parameter int DIGIT_H = 40,
   parameter int SEG_T   = 4
) (
   input  logic [3:0] value,
   input  logic [9:0] org_x,
   input  logic [9:0] org_y,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic       on
);

   localparam logic [10:0] W      = 11'(DIGIT_W);
   localparam logic [10:0] H      = 11'(DIGIT_H);
   localparam logic [10:0] T      = 11'(SEG_T);
   localparam logic [10:0] HALF   = 11'(DIGIT_H / 2);
   localparam logic [10:0] G_TOP  = 11'(DIGIT_H / 2 - SEG_T / 2);
   localparam logic [10:0] G_BOT  = 11'(DIGIT_H / 2 + SEG_T / 2);

   logic [10:0] dx;
   logic [10:0] dy;
   logic        in_box;
   logic        upper;
   logic        left;
   logic        right;
   logic [6:0]  hit;

   assign dx     = {1'b0, x} - {1'b0, org_x};
   assign dy     = {1'b0, y} - {1'b0, org_y};
   assign in_box = (x >= org_x) && (y >= org_y) && (dx < W) && (dy < H);
   assign upper  = dy < HALF;
   assign left   = dx < T;
   assign right  = dx >= (W - T);

   // Segment masks in {a,b,c,d,e,f,g} order, matching the glyph constants.
   assign hit = {
      dy < T,
      right & upper,
      right & ~upper,
      dy >= (H - T),
      left & ~upper,
      left & upper,
      (dy >= G_TOP) && (dy < G_BOT)
   };

   assign on = in_box & (|(hit & seg_pattern(value)));

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// score_keeper: miss detection, scoring and serve/game-over sequencing for two players,
// with an optional seven-segment score overlay enabled by SCORE_DISPLAY_EN.
`default_nettype none

module score_keeper
   import score_keeper_pkg::*;
#(
   parameter int         MISS_L       = 10,
   parameter int         MISS_R       = 630,
   parameter int         WIN_SCORE    = 9,
   parameter int         SERVE_FRAMES = 60,
   parameter int         P1_DIGIT_X   = 400,
   parameter int         P2_DIGIT_X   = 220,
   parameter int         DIGIT_Y      = 20,
   parameter int         DIGIT_W      = 20,
   parameter int         DIGIT_H      = 40,
   parameter int         SEG_T        = 4,
   parameter logic [7:0] SCORE_RGB    = 8'hFF
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [9:0] ball_x_l,
   input  logic [9:0] ball_x_r,
   input  logic [9:0] ball_y_t,
   input  logic [9:0] ball_y_b,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic       ball_reset,
   output logic       game_over,
   output logic       winner,
   output logic       score_on,
   output logic [7:0] score_rgb
);

   localparam int             CNT_W      = $clog2(SERVE_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [3:0]     WIN        = 4'(WIN_SCORE);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             miss_l;
   logic             miss_r;
   logic [3:0]       p1_inc;
   logic [3:0]       p2_inc;
   logic             point_wins;

   assign miss_l     = ball_x_l < 10'(MISS_L);
   assign miss_r     = ball_x_r > 10'(MISS_R);
   assign p1_inc     = sat_inc(score_p1);
   assign p2_inc     = sat_inc(score_p2);
   // A simultaneous double miss is credited to the left side only.
   assign point_wins = miss_l ? (p1_inc == WIN) : (p2_inc == WIN);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= IDLE;
         cnt      <= '0;
         score_p1 <= 4'd0;
         score_p2 <= 4'd0;
         winner   <= 1'b0;
      end else begin
         case (state)
            IDLE, OVER: begin
               if (start) begin
                  score_p1 <= 4'd0;
                  score_p2 <= 4'd0;
                  cnt      <= '0;
                  state    <= SERVE;
               end
            end
            SERVE: begin
               if (frame_tick) begin
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= PLAY;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            PLAY: begin
               if (frame_tick && (miss_l || miss_r)) begin
                  if (miss_l) begin
                     score_p1 <= p1_inc;
                  end else begin
                     score_p2 <= p2_inc;
                  end
                  if (point_wins) begin
                     winner <= ~miss_l;
                     state  <= OVER;
                  end else begin
                     cnt   <= '0;
                     state <= SERVE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ball_reset = (state != PLAY);
   assign game_over  = (state == OVER);

`ifdef SCORE_DISPLAY_EN
   logic on_p1;
   logic on_p2;
   logic unused_ok;

   seg_digit #(
      .DIGIT_W (DIGIT_W),
      .DIGIT_H (DIGIT_H),
      .SEG_T   (SEG_T)
   ) u_digit_p1 (
      .value (score_p1),
      .org_x (10'(P1_DIGIT_X)),
      .org_y (10'(DIGIT_Y)),
      .x     (x),
      .y     (y),
      .on    (on_p1)
   );

   seg_digit #(
      .DIGIT_W (DIGIT_W),
      .DIGIT_H (DIGIT_H),
      .SEG_T   (SEG_T)
   ) u_digit_p2 (
      .value (score_p2),
      .org_x (10'(P2_DIGIT_X)),
      .org_y (10'(DIGIT_Y)),
      .x     (x),
      .y     (y),
      .on    (on_p2)
   );

   assign score_on  = on_p1 | on_p2;
   assign score_rgb = SCORE_RGB;
   assign unused_ok = ^{ball_y_t, ball_y_b};
`else
   logic unused_ok;

   assign score_on  = 1'b0;
   assign score_rgb = 8'h00;
   assign unused_ok = ^{ball_y_t, ball_y_b, x, y};
`endif

endmodule

`default_nettype wire

// File: doc/score_keeper.md
# score_keeper

Game-control stage that sits downstream of the ball and paddle objects and feeds the pixel RGB multiplexer. It watches the ball's bounding box once per frame, detects misses past either paddle, and keeps both players' scores. It sequences serve and game-over, drives a ball re-centre request back to the ball object, and renders both scores as seven-segment digits for the current pixel.

## Interface
- MISS_L, 10: ball_x_l strictly below this value is a miss on the left side.
- MISS_R, 630: ball_x_r strictly above this value is a miss on the right side.
- WIN_SCORE, 9: score at which the game ends (1..15).
- SERVE_FRAMES, 60: frame ticks the ball is held centred after a point.
- P1_DIGIT_X, 400 / P2_DIGIT_X, 220 / DIGIT_Y, 20: top-left of each digit box.
- DIGIT_W, 20 / DIGIT_H, 40 / SEG_T, 4: digit box size and segment thickness in pixels.
- SCORE_RGB, 8'hFF: overlay colour.
- CLK  in  1  system clock (12 MHz); all state on rising edge.
- RST_N  in  1  synchronous active-low reset.
- frame_tick  in  1  one-cycle pulse per frame (paddle/ball update rate).
- start  in  1  debounced one-cycle start pulse.
- ball_x_l, ball_x_r, ball_y_t, ball_y_b  in  10 each  current ball box.
- x, y  in  10 each  current pixel from the VGA timing block.
- score_p1, score_p2  out  4 each  scores. P1 is the right-hand paddle, P2 the left-hand paddle.
- ball_reset  out  1  ball must hold at centre while high.
- game_over  out  1  high in OVER.
- winner  out  1  0 = P1, 1 = P2; valid while game_over.
- score_on  out  1  current pixel lies on a lit segment.
- score_rgb  out  8  overlay colour (SCORE_RGB).

## Operation
- FSM states: IDLE, SERVE, PLAY, OVER. Reset state is IDLE.
- IDLE:
  - ball_reset=1.
  - On start, clear both scores, clear the frame counter, and go to SERVE.
- SERVE:
  - ball_reset=1.
  - Count frame_tick. After SERVE_FRAMES ticks, go to PLAY.
  - start is ignored.
- PLAY:
  - ball_reset=0. Miss checks run only on cycles with frame_tick.
  - Left miss (ball_x_l < MISS_L): score_p1 += 1.
  - Right miss (ball_x_r > MISS_R): score_p2 += 1.
  - If both miss conditions hold on the same tick, only the left miss counts.
  - After a point: if the new score equals WIN_SCORE, go to OVER and set winner. Otherwise go to SERVE with the frame counter cleared.
  - start is ignored.
- OVER:
  - ball_reset=1, game_over=1. Scores and winner are held.
  - On start, clear the scores and go to SERVE.
- Scores saturate at 15 and never wrap. WIN_SCORE ≤ 15 guarantees OVER is reached first.
- Overlay:
  - Combinational decode of (x, y) against two digit boxes.
  - Digits shown are score_p1 at P1_DIGIT_X and score_p2 at P2_DIGIT_X.
  - Segments a–g are SEG_T-thick bars inside the DIGIT_W×DIGIT_H box.
  - Values 10..15 render as hex A–F.
  - score_on=0 outside both boxes and for unlit segments.

## Timing
- Reset values:
  - score_p1=0, score_p2=0, ball_reset=1, game_over=0, winner=0.
  - Frame counter 0, state IDLE.
- Score update and state change both occur at the CLK edge that samples frame_tick=1 with a miss. Outputs are visible the next cycle.
- ball_reset and game_over are decoded from registered state: no glitches, one cycle after the state transition.
- The SERVE→PLAY edge is the SERVE_FRAMES-th frame_tick after entering SERVE.
- score_on has zero-cycle latency from x, y, so it stays pixel-aligned with the other object signals.
- RST_N low mid-game returns to IDLE on that edge, whatever the state and pending frame_tick or start.
- start and frame_tick on the same cycle in IDLE or OVER: start wins, and that frame_tick is not counted.

## Configuration
- SCORE_DISPLAY_EN defined: digit renderer instantiated, score_on driven as above.
- SCORE_DISPLAY_EN undefined: renderer omitted, score_on tied 0, score_rgb tied 0. Scoring and FSM are unchanged.

## Structure
- Shared package holds:
  - FSM state enum (IDLE, SERVE, PLAY, OVER).
  - 7-bit segment pattern constants for 0–F.
  - Screen constants MAX_X=640 and MAX_Y=480.
- Sub-module seg_digit:
  - Takes a 4-bit value, box origin, x and y; returns `on`.
  - Instantiated twice under SCORE_DISPLAY_EN.

## Test plan
- Reset, then start pulse, then 60 frame ticks with the ball centred → scores 0/0, ball_reset falls after the 60th tick, state PLAY.
- PLAY, ball_x_l=5 on one frame_tick → score_p1=1, ball_reset=1 next cycle, PLAY again after 60 ticks.
- PLAY, ball_x_l=5 and ball_x_r=635 on the same tick → only score_p1 increments.
- score_p2=8, right miss → score_p2=9, game_over=1, winner=1. Further misses leave the scores unchanged. Start → 0/0 and SERVE.
- RST_N low for one cycle during SERVE with scores 3/4 → next cycle IDLE, scores 0/0, game_over=0.
- score_p1=8, x=P1_DIGIT_X+10, y=DIGIT_Y+1 (segment a) → score_on=1. Same pixel with score 1 → score_on=0. Without SCORE_DISPLAY_EN → always 0.
